// File: rtl/ones_counter.sv
// Registered population count: counts set bits of num and presents the count,
// parity, all-zero and all-ones flags one clock later with a valid strobe.
module ones_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] num,
  input  logic             in_valid,
  output logic [CNT_W-1:0] res,
  output logic             out_valid,
  output logic             parity,
  output logic             zero,
  output logic             all_ones
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] res_d, res_q;
  logic             out_valid_d, out_valid_q;
  logic             parity_d, parity_q;
  logic             zero_d, zero_q;
  logic             all_ones_d, all_ones_q;

  // Adder chain over the input bits; synthesis rebalances it into a tree.
  // NOTE: combinational blocks use blocking '=' so each iteration sees the
  // running sum from the previous one.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(num[i]);
    end
  end

  // Flags come from the same count so they can never disagree with res.
  always_comb begin
    // NOTE: every output gets its hold value first so no path leaves a
    // signal unassigned, which would infer a latch.
    res_d       = res_q;
    parity_d    = parity_q;
    zero_d      = zero_q;
    all_ones_d  = all_ones_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      res_d       = cnt;
      parity_d    = cnt[0];
      zero_d      = (cnt == '0);
      all_ones_d  = (cnt == FULL_CNT);
      out_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      parity_q    <= 1'b0;
      zero_q      <= 1'b1;
      all_ones_q  <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      parity_q    <= parity_d;
      zero_q      <= zero_d;
      all_ones_q  <= all_ones_d;
    end
  end

  assign res       = res_q;
  assign out_valid = out_valid_q;
  assign parity    = parity_q;
  assign zero      = zero_q;
  assign all_ones  = all_ones_q;

endmodule

// File: tb/tb_ones_counter.sv
// Self-checking bench for ones_counter: directed cases plus random stream
// compared against a behavioural popcount model.
module tb_ones_counter;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] num;
  logic             in_valid;
  logic [CNT_W-1:0] res;
  logic             out_valid;
  logic             parity;
  logic             zero;
  logic             all_ones;

  int total = 0;
  int bad   = 0;

  // Reference state: what the outputs must show after the latest edge.
  int m_res;
  bit m_ov, m_par, m_zero, m_all;

  ones_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .num       (num),
    .in_valid  (in_valid),
    .res       (res),
    .out_valid (out_valid),
    .parity    (parity),
    .zero      (zero),
    .all_ones  (all_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_res = 0; m_ov = 0; m_par = 0; m_zero = 1; m_all = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".res"},       32'(res),       32'(m_res));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    check({tag, ".parity"},    32'(parity),    32'(m_par));
    check({tag, ".zero"},      32'(zero),      32'(m_zero));
    check({tag, ".all_ones"},  32'(all_ones),  32'(m_all));
  endtask

  // Drive one word from a negedge, clock it in, sample at the next negedge.
  task automatic step(input bit iv, input logic [WIDTH-1:0] n);
    in_valid = iv;
    num      = n;
    @(posedge clk);
    if (iv) begin
      m_res  = $countones(n);
      m_par  = ^n;
      m_zero = (n == '0);
      m_all  = (n == '1);
      m_ov   = 1;
    end else begin
      m_ov   = 0;
    end
    @(negedge clk);
  endtask

  int sweep_exp [16] = '{0, 2, 2, 4, 2, 4, 4, 6, 2, 4, 4, 6, 4, 6, 6, 8};

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    num      = '0;
    model_reset();

    // Asynchronous reset asserted between edges.
    #2 rst_n = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("reset_hold");

    // Nibble-pair sweep, back to back.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 8'(k * 8'h11));
      check($sformatf("sweep%0d.res_table", k), 32'(res), 32'(sweep_exp[k]));
      check_all($sformatf("sweep%0d", k));
    end

    // Odd counts.
    step(1'b1, 8'h01); check("odd01.res", 32'(res), 1); check("odd01.par", 32'(parity), 1);
    step(1'b1, 8'h7F); check("odd7f.res", 32'(res), 7); check("odd7f.par", 32'(parity), 1);
    step(1'b1, 8'h80); check("odd80.res", 32'(res), 1); check("odd80.zero", 32'(zero), 0);
    check_all("odd80");

    // Hold: unsampled 0xFF must not disturb the held result.
    step(1'b1, 8'h55); check("hold55.res", 32'(res), 4); check("hold55.ov", 32'(out_valid), 1);
    step(1'b0, 8'hFF); check("holdff.res", 32'(res), 4); check("holdff.ov", 32'(out_valid), 0);
    check("holdff.all_ones", 32'(all_ones), 0);
    step(1'b0, 8'hFF); check_all("hold2");

    // Mid-stream reset: 0xFF in flight is discarded.
    step(1'b1, 8'hAA); check_all("mid_aa");
    in_valid = 1'b1;
    num      = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all("mid_release1");
    step(1'b0, 8'hFF); check_all("mid_release2");

    // Random stream against the reference model.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom));
      check_all($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d.zero_cons", i), 32'(zero), 32'(res == 0));
      check($sformatf("rnd%0d.all_cons", i), 32'(all_ones), 32'(res == WIDTH));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
